envelope_adsr: RTL and testbench

Amplitude-envelope stage between the waveform generator and the PDM modulator. It takes the 16-bit offset-binary PCM stream and scales its deviation from midscale by an 8-bit ADSR envelope driven by a gate input. The scaled PCM goes to the PDM stage. The envelope runs from a clock-divided tick, so one block covers audible attack and release times directly at the system clock.

---
 rtl/envelope_pkg.sv | 19 +
 rtl/envelope_tick.sv | 48 ++++
 rtl/envelope_adsr.sv | 162 ++++++++++++++++
 tb/tb_envelope_adsr.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/envelope_pkg.sv
// Shared definitions for the ADSR amplitude-envelope stage.
package envelope_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ATTACK  = 3'd1,
      ST_DECAY   = 3'd2,
      ST_SUSTAIN = 3'd3,
      ST_RELEASE = 3'd4
   } env_state_e;

   localparam logic [7:0] ENV_MAX = 8'd255;

   // Offset-binary midscale for a given sample width.
   function automatic logic [31:0] midscale(input int unsigned pcm_w);
      return 32'd1 << (pcm_w - 1);
   endfunction

endpackage

// File: rtl/envelope_tick.sv
// Envelope step generator: a base-tick prescaler followed by a rate compare.
// A step fires once every PRESCALE*(rate+1) cycles after the last clear.
module envelope_tick #(
   parameter int PRESCALE = 256
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic [3:0] rate,
   output logic       step
);

   localparam int              PS_W    = $clog2(PRESCALE);
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

   logic [PS_W-1:0] presc_q, presc_d;
   logic [3:0]      rcnt_q, rcnt_d;
   logic            base_tick;

   // Next-count logic; clear overrides counting so a new state starts fresh.
   always_comb begin
      base_tick = (presc_q == PS_LAST);
      step      = base_tick && (rcnt_q == rate);
      presc_d   = base_tick ? '0 : presc_q + 1'b1;
      rcnt_d    = rcnt_q;
      if (step) begin
         rcnt_d = '0;
      end else if (base_tick) begin
         rcnt_d = rcnt_q + 1'b1;
      end
      if (clear) begin
         presc_d = '0;
         rcnt_d  = '0;
      end
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         presc_q <= '0;
         rcnt_q  <= '0;
      end else begin
         presc_q <= presc_d;
         rcnt_q  <= rcnt_d;
      end
   end

endmodule

// File: rtl/envelope_adsr.sv
// ADSR amplitude envelope: scales the PCM deviation from midscale by an
// 8-bit envelope level driven by a gate.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | silent, level 0, step counters held clear
// ATTACK  | level rises 1 per attack step until 255
// DECAY   | level falls 1 per decay step down to sustain_level
// SUSTAIN | level follows sustain_level every cycle, counters held clear
// RELEASE | level falls 1 per release step until 0
module envelope_adsr
   import envelope_pkg::*;
#(
   parameter int PCM_W    = 16,
   parameter int PRESCALE = 256
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             gate,
   input  logic [3:0]       attack_rate,
   input  logic [3:0]       decay_rate,
   input  logic [7:0]       sustain_level,
   input  logic [3:0]       release_rate,
   input  logic [PCM_W-1:0] pcm_in,
   output logic [PCM_W-1:0] pcm_out,
   output logic [7:0]       env_level,
   output logic [2:0]       env_state,
   output logic             busy
);

   localparam logic [PCM_W-1:0] MID    = PCM_W'(midscale(PCM_W));
   localparam int               PROD_W = PCM_W + 10;

   env_state_e state_q, state_d;
   logic [7:0] level_q, level_d;
   logic       gate_q, rise_q, fall_q;
   logic       busy_q, busy_d;
   logic       tick_clear, step;
   logic [3:0] rate_sel;

   envelope_tick #(
      .PRESCALE(PRESCALE)
   ) u_tick (
      .clk  (clk),
      .reset(reset),
      .clear(tick_clear),
      .rate (rate_sel),
      .step (step)
   );

   // Gate sampling; edges are registered so a toggle reaches the state
   // register two cycles after the pin changes.
   always_ff @(posedge clk) begin
      if (reset) begin
         gate_q <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         gate_q <= gate;
         rise_q <= gate & ~gate_q;
         fall_q <= ~gate & gate_q;
      end
   end

   // State, level and busy registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         level_q <= 8'd0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         busy_q  <= busy_d;
      end
   end

   // Next state and level; gate edges take priority and swallow any step.
   always_comb begin
      state_d = state_q;
      level_d = level_q;
      if (rise_q) begin
         state_d = ST_ATTACK;
      end else if (fall_q && (state_q inside {ST_ATTACK, ST_DECAY, ST_SUSTAIN})) begin
         state_d = ST_RELEASE;
      end else begin
         case (state_q)
            ST_ATTACK: begin
               if (level_q == ENV_MAX) begin
                  state_d = ST_DECAY;
               end else if (step) begin
                  level_d = level_q + 8'd1;
                  if (level_d == ENV_MAX) state_d = ST_DECAY;
               end
            end
            ST_DECAY: begin
               if (level_q <= sustain_level) begin
                  level_d = sustain_level;
                  state_d = ST_SUSTAIN;
               end else if (step) begin
                  level_d = level_q - 8'd1;
               end
            end
            ST_SUSTAIN: level_d = sustain_level;
            ST_RELEASE: begin
               if (level_q == 8'd0) begin
                  state_d = ST_IDLE;
               end else if (step) begin
                  level_d = level_q - 8'd1;
                  if (level_q == 8'd1) state_d = ST_IDLE;
               end
            end
            default: ;
         endcase
      end
   end

   // Step-timer control and busy; counters restart on any state change.
   always_comb begin
      tick_clear = (state_d != state_q) || (state_q == ST_IDLE) || (state_q == ST_SUSTAIN);
      busy_d     = (state_d != ST_IDLE);
      case (state_q)
         ST_ATTACK:  rate_sel = attack_rate;
         ST_DECAY:   rate_sel = decay_rate;
         ST_RELEASE: rate_sel = release_rate;
         default:    rate_sel = 4'd0;
      endcase
   end

   assign env_level = level_q;
   assign env_state = state_q;
   assign busy      = busy_q;

   // Scaling datapath. Gain 255 is bumped to 256 so full level is unity.
   logic signed [PCM_W-1:0]  diff;
   logic [8:0]               gain;
   logic signed [PROD_W-1:0] prod_full;
   logic [PCM_W-1:0]         prod_q;
   logic [PCM_W-1:0]         pcm_out_q;
   logic                     unused_prod_bits;

   assign diff      = $signed(pcm_in ^ MID);
   assign gain      = {1'b0, level_q} + {8'd0, level_q[7]};
   assign prod_full = PROD_W'(diff) * $signed({{(PROD_W - 9){1'b0}}, gain});
   // Only (d*g)>>>8 truncated to PCM_W bits is needed; the product cannot
   // exceed that range, so the top and fractional bits are dropped.
   assign unused_prod_bits = ^{prod_full[PROD_W-1:PCM_W+8], prod_full[7:0]};

   // Two-stage pipeline: scaled deviation, then midscale offset.
   always_ff @(posedge clk) begin
      if (reset) begin
         prod_q    <= '0;
         pcm_out_q <= MID;
      end else begin
         prod_q    <= prod_full[PCM_W+7:8];
         pcm_out_q <= prod_q ^ MID;
      end
   end

   assign pcm_out = pcm_out_q;

endmodule

// File: tb/tb_envelope_adsr.sv
module tb_envelope_adsr;

   localparam int P = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        gate;
   logic [3:0]  attack_rate, decay_rate, release_rate;
   logic [7:0]  sustain_level;
   logic [15:0] pcm_in;
   logic [15:0] pcm_out;
   logic [7:0]  env_level;
   logic [2:0]  env_state;
   logic        busy;

   int errors = 0;
   int checks = 0;

   localparam logic [2:0] S_IDLE = 3'd0, S_ATK = 3'd1, S_DEC = 3'd2, S_SUS = 3'd3, S_REL = 3'd4;

   envelope_adsr #(.PCM_W(16), .PRESCALE(P)) dut (
      .clk          (clk),
      .reset        (reset),
      .gate         (gate),
      .attack_rate  (attack_rate),
      .decay_rate   (decay_rate),
      .sustain_level(sustain_level),
      .release_rate (release_rate),
      .pcm_in       (pcm_in),
      .pcm_out      (pcm_out),
      .env_level    (env_level),
      .env_state    (env_state),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference scaling: midscale + floor((x - mid) * g / 256), g = lvl + lvl[7].
   function automatic logic [15:0] model_pcm(input logic [15:0] x, input logic [7:0] lvl);
      int d, g, p, q;
      d = int'(x) - 32768;
      g = int'(lvl) + ((lvl >= 8'd128) ? 1 : 0);
      p = d * g;
      q = (p >= 0) ? (p / 256) : -((-p + 255) / 256);
      return 16'(32768 + q);
   endfunction

   task automatic test_reset();
      bit bad = 0;
      reset = 1; gate = 0; pcm_in = 16'hFFFF;
      attack_rate = 0; decay_rate = 1; release_rate = 0; sustain_level = 8'h80;
      repeat (3) tick();
      reset = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (!bad && (pcm_out !== 16'h8000 || env_level !== 8'd0 || busy !== 1'b0 || env_state !== S_IDLE)) begin
            bad = 1; errors++;
            $display("FAIL reset_hold cyc=%0d: pcm_out=%h level=%h busy=%b state=%0d, want 8000/00/0/0",
                     i, pcm_out, env_level, busy, env_state);
         end
      end
      checks++;
   endtask

   task automatic test_attack();
      bit bad = 0;
      gate = 1;
      tick();
      checks++;
      if (env_state !== S_IDLE) begin
         errors++; $display("FAIL attack_latency1: state=%0d want 0", env_state);
      end
      tick();
      checks++;
      if (env_state !== S_ATK || env_level !== 8'd0 || busy !== 1'b1) begin
         errors++; $display("FAIL attack_entry: state=%0d level=%h busy=%b want 1/00/1", env_state, env_level, busy);
      end
      for (int n = 1; n < 1020; n++) begin
         tick();
         if (!bad && (env_state !== S_ATK || env_level !== 8'(n / 4))) begin
            bad = 1; errors++;
            $display("FAIL attack_ramp n=%0d: state=%0d level=%h want 1/%h", n, env_state, env_level, 8'(n / 4));
         end
      end
      checks++;
      tick();
      checks++;
      if (env_state !== S_DEC || env_level !== 8'hFF) begin
         errors++; $display("FAIL attack_top: state=%0d level=%h want 2/ff", env_state, env_level);
      end
   endtask

   task automatic test_decay();
      bit bad = 0;
      for (int m = 1; m <= 1016; m++) begin
         tick();
         if (!bad && (env_state !== S_DEC || env_level !== 8'(255 - m / 8))) begin
            bad = 1; errors++;
            $display("FAIL decay_ramp m=%0d: state=%0d level=%h want 2/%h", m, env_state, env_level, 8'(255 - m / 8));
         end
      end
      checks++;
      tick();
      checks++;
      if (env_state !== S_SUS || env_level !== 8'h80) begin
         errors++; $display("FAIL sustain_entry: state=%0d level=%h want 3/80", env_state, env_level);
      end
      sustain_level = 8'h40;
      tick();
      checks++;
      if (env_state !== S_SUS || env_level !== 8'h40) begin
         errors++; $display("FAIL sustain_track: state=%0d level=%h want 3/40", env_state, env_level);
      end
   endtask

   task automatic test_scaling();
      logic [15:0] hist[32];
      logic [15:0] x, exp_v;
      logic [7:0]  s;
      bit bad = 0;
      sustain_level = 8'hFF;
      tick();
      pcm_in = 16'hFFFF; tick();
      pcm_in = 16'h0000; tick();
      checks++;
      if (pcm_out !== 16'hFFFF) begin
         errors++; $display("FAIL scale_full_hi: pcm_out=%h want ffff", pcm_out);
      end
      tick();
      checks++;
      if (pcm_out !== 16'h0000) begin
         errors++; $display("FAIL scale_full_lo: pcm_out=%h want 0000", pcm_out);
      end
      sustain_level = 8'h80;
      tick();
      pcm_in = 16'hFFFF; tick(); tick();
      checks++;
      exp_v = model_pcm(16'hFFFF, 8'h80);
      if (pcm_out !== exp_v) begin
         errors++; $display("FAIL scale_half_hi: pcm_out=%h want %h", pcm_out, exp_v);
      end
      pcm_in = 16'h0000; tick(); tick();
      checks++;
      exp_v = model_pcm(16'h0000, 8'h80);
      if (pcm_out !== exp_v) begin
         errors++; $display("FAIL scale_half_lo: pcm_out=%h want %h", pcm_out, exp_v);
      end
      for (int i = 0; i < 24; i++) begin
         s = 8'($urandom);
         x = 16'($urandom);
         sustain_level = s;
         tick();
         pcm_in = x;
         tick(); tick();
         checks++;
         exp_v = model_pcm(x, s);
         if (pcm_out !== exp_v) begin
            errors++; $display("FAIL scale_rand%0d: x=%h lvl=%h pcm_out=%h want %h", i, x, s, pcm_out, exp_v);
         end
      end
      s = 8'($urandom_range(1, 255));
      sustain_level = s;
      tick();
      for (int i = 0; i < 32; i++) begin
         hist[i] = 16'($urandom);
         pcm_in = hist[i];
         tick();
         if (i >= 1) begin
            exp_v = model_pcm(hist[i-1], s);
            if (!bad && pcm_out !== exp_v) begin
               bad = 1; errors++;
               $display("FAIL scale_stream i=%0d: pcm_out=%h want %h", i, pcm_out, exp_v);
            end
         end
      end
      checks++;
   endtask

   task automatic test_release_from_attack();
      int cnt;
      bit bad = 0;
      release_rate = 0;
      gate = 0;
      cnt = 0;
      while (busy !== 1'b0 && cnt < 1200) begin tick(); cnt++; end
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL release_to_idle: busy=%b want 0", busy);
      end
      attack_rate = 0;
      gate = 1;
      cnt = 0;
      while (env_level !== 8'h30 && cnt < 400) begin tick(); cnt++; end
      checks++;
      if (env_level !== 8'h30 || env_state !== S_ATK) begin
         errors++; $display("FAIL attack_to_30: level=%h state=%0d want 30/1", env_level, env_state);
      end
      gate = 0;
      tick(); tick();
      checks++;
      if (env_state !== S_REL || env_level !== 8'h30) begin
         errors++; $display("FAIL release_entry: state=%0d level=%h want 4/30", env_state, env_level);
      end
      for (int m = 1; m < 192; m++) begin
         tick();
         if (!bad && (env_state !== S_REL || env_level !== 8'(48 - m / 4) || busy !== 1'b1)) begin
            bad = 1; errors++;
            $display("FAIL release_ramp m=%0d: state=%0d level=%h want 4/%h", m, env_state, env_level, 8'(48 - m / 4));
         end
      end
      checks++;
      tick();
      checks++;
      if (env_state !== S_IDLE || env_level !== 8'd0 || busy !== 1'b0) begin
         errors++; $display("FAIL release_end: state=%0d level=%h busy=%b want 0/00/0", env_state, env_level, busy);
      end
   endtask

   task automatic test_retrigger_and_reset();
      int cnt;
      attack_rate = 0; release_rate = 0;
      gate = 1;
      cnt = 0;
      while (env_level !== 8'h40 && cnt < 400) begin tick(); cnt++; end
      gate = 0;
      cnt = 0;
      while (!(env_state === S_REL && env_level === 8'h20) && cnt < 400) begin tick(); cnt++; end
      checks++;
      if (env_state !== S_REL || env_level !== 8'h20) begin
         errors++; $display("FAIL release_to_20: state=%0d level=%h want 4/20", env_state, env_level);
      end
      gate = 1;
      tick(); tick();
      checks++;
      if (env_state !== S_ATK || env_level !== 8'h20) begin
         errors++; $display("FAIL retrigger_entry: state=%0d level=%h want 1/20", env_state, env_level);
      end
      tick(); tick(); tick();
      checks++;
      if (env_level !== 8'h20) begin
         errors++; $display("FAIL retrigger_hold: level=%h want 20", env_level);
      end
      tick();
      checks++;
      if (env_level !== 8'h21) begin
         errors++; $display("FAIL retrigger_step: level=%h want 21", env_level);
      end
      pcm_in = 16'hFFFF;
      tick(); tick();
      reset = 1;
      tick();
      checks++;
      if (env_state !== S_IDLE || env_level !== 8'd0 || busy !== 1'b0 || pcm_out !== 16'h8000) begin
         errors++; $display("FAIL reset_mid: state=%0d level=%h busy=%b pcm_out=%h want 0/00/0/8000",
                            env_state, env_level, busy, pcm_out);
      end
      tick();
      reset = 0;
      tick();
      checks++;
      if (env_state !== S_IDLE || pcm_out !== 16'h8000) begin
         errors++; $display("FAIL reset_gate_high1: state=%0d pcm_out=%h want 0/8000", env_state, pcm_out);
      end
      tick();
      checks++;
      if (env_state !== S_ATK || env_level !== 8'd0) begin
         errors++; $display("FAIL reset_gate_high2: state=%0d level=%h want 1/00", env_state, env_level);
      end
   endtask

   task automatic test_random_env();
      int cnt, ta, td, tr, s, k, span, lvl, st;
      bit bad;
      release_rate = 0;
      gate = 0;
      cnt = 0;
      while (busy !== 1'b0 && cnt < 1200) begin tick(); cnt++; end
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL rand_idle: busy=%b want 0", busy);
      end
      for (int it = 0; it < 3; it++) begin
         attack_rate   = 4'($urandom_range(0, 3));
         decay_rate    = 4'($urandom_range(0, 3));
         release_rate  = 4'($urandom_range(0, 3));
         s             = $urandom_range(16, 255);
         sustain_level = 8'(s);
         ta = P * (int'(attack_rate) + 1);
         td = P * (int'(decay_rate) + 1);
         tr = P * (int'(release_rate) + 1);
         k  = (255 - s) * td;
         gate = 1;
         tick(); tick();
         span = 255 * ta + k + 3;
         bad = 0;
         for (int n = 0; n <= span; n++) begin
            if (n > 0) tick();
            if (n < 255 * ta) begin
               lvl = n / ta; st = 1;
            end else if (n - 255 * ta <= k) begin
               lvl = 255 - (n - 255 * ta) / td; st = 2;
            end else begin
               lvl = s; st = 3;
            end
            if (!bad && (env_level !== 8'(lvl) || env_state !== 3'(st))) begin
               bad = 1; errors++;
               $display("FAIL rand_ads it=%0d n=%0d: level=%h state=%0d want %h/%0d", it, n, env_level, env_state, 8'(lvl), st);
            end
         end
         checks++;
         gate = 0;
         tick(); tick();
         bad = 0;
         for (int m = 0; m <= s * tr + 2; m++) begin
            if (m > 0) tick();
            if (m < s * tr) begin
               lvl = s - m / tr; st = 4;
            end else begin
               lvl = 0; st = 0;
            end
            if (!bad && (env_level !== 8'(lvl) || env_state !== 3'(st) || busy !== (st != 0))) begin
               bad = 1; errors++;
               $display("FAIL rand_rel it=%0d m=%0d: level=%h state=%0d busy=%b want %h/%0d", it, m, env_level, env_state, busy, 8'(lvl), st);
            end
         end
         checks++;
      end
   endtask

   initial begin
      test_reset();
      test_attack();
      test_decay();
      test_scaling();
      test_release_from_attack();
      test_retrigger_and_reset();
      test_random_env();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
